bias_sched: RTL and testbench

BIAS_SCHED -- requirements
Module: bias_sched

---
 rtl/bias_sched.sv | 150 +++++++++++++++
 tb/tb_bias_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_sched.sv
// Bias word scheduler: prefetches one 512-bit bias word per output-channel group
// into a 2-entry FIFO and holds it on the adder port for part_num NPE beats.
module bias_sched #(
  parameter int RAM_ADDR_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_calc_en,
  input  logic                      i_calculate_end,
  input  logic [RAM_ADDR_WIDTH-1:0] i_addr_start_b,
  input  logic [7:0]                i_output_layers,
  input  logic [4:0]                i_part_num,
  input  logic                      i_npe_dat_vld,
  output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
  output logic                      o_ram_rd_en,
  input  logic                      i_ram_dat_vld,
  input  logic [511:0]              i_ram_dat,
  output logic [511:0]              o_bias_dat,
  output logic                      o_bias_vld,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_underflow
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  state_t                    state_q;
  logic [RAM_ADDR_WIDTH-1:0] start_q;
  logic [RAM_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                layers_q;
  logic [7:0]                reads_q;
  logic [7:0]                groups_q;
  logic [4:0]                part_q;
  logic [4:0]                beat_q;
  logic [1:0]                fifo_cnt_q;
  logic [1:0]                outst_q;
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [511:0]              fifo_q [2];
  logic                      rd_en_q;
  logic                      underflow_q;

  logic       running;
  logic       abort;
  logic       push;
  logic       beat;
  logic       pop;
  logic       issue;
  logic       uflow_evt;
  logic [4:0] part_last;
  logic [2:0] occupancy;

  assign running   = (state_q == S_FETCH) || (state_q == S_RUN);
  assign abort     = (state_q != S_IDLE) && i_calculate_end;
  assign part_last = (part_q == 5'd0) ? 5'd0 : part_q - 5'd1;
  // Words buffered plus words still in flight from the RAM; capped at the FIFO depth.
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, outst_q};

  assign o_bias_vld = (state_q == S_RUN) && (fifo_cnt_q != 2'd0);
  assign push       = i_ram_dat_vld && (outst_q != 2'd0) && !abort;
  assign beat       = i_npe_dat_vld && o_bias_vld && !abort;
  assign pop        = beat && (beat_q == part_last);
  assign uflow_evt  = running && i_npe_dat_vld && !o_bias_vld;
  assign issue      = running && !abort && (reads_q < layers_q) && (occupancy < 3'd2);

  assign o_ram_rd_en = rd_en_q;
  assign o_ram_addr  = addr_q;
  assign o_bias_dat  = fifo_q[rd_ptr_q];
  assign o_busy      = running;
  assign o_done      = (state_q == S_DONE);
  assign o_underflow = underflow_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      start_q     <= '0;
      addr_q      <= '0;
      layers_q    <= '0;
      reads_q     <= '0;
      groups_q    <= '0;
      part_q      <= '0;
      beat_q      <= '0;
      fifo_cnt_q  <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      underflow_q <= 1'b0;
      // NOTE: the FIFO storage is reset too, since o_bias_dat must read 0 out of reset.
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else begin
      rd_en_q <= issue;
      if (issue) begin
        addr_q  <= start_q + RAM_ADDR_WIDTH'(reads_q);
        reads_q <= reads_q + 8'd1;
      end
      outst_q <= outst_q + {1'b0, issue} - {1'b0, push};

      if (push) begin
        fifo_q[wr_ptr_q] <= i_ram_dat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        groups_q <= groups_q + 8'd1;
        beat_q   <= '0;
      end else if (beat) begin
        beat_q <= beat_q + 5'd1;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      if (uflow_evt) underflow_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (i_calc_en) begin
            start_q     <= i_addr_start_b;
            layers_q    <= i_output_layers;
            part_q      <= i_part_num;
            reads_q     <= '0;
            groups_q    <= '0;
            beat_q      <= '0;
            underflow_q <= 1'b0;
            state_q     <= (i_output_layers == 8'd0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: if (push) state_q <= S_RUN;
        S_RUN:   if (pop && (groups_q + 8'd1 == layers_q)) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // NOTE: the last non-blocking assignment to a register wins, so this abort
      // block overrides every push/pop/issue update made above in the same cycle.
      if (abort) begin
        state_q    <= S_IDLE;
        reads_q    <= '0;
        groups_q   <= '0;
        beat_q     <= '0;
        fifo_cnt_q <= '0;
        outst_q    <= '0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        rd_en_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bias_sched.sv
// Self-checking bench for bias_sched: table of layer passes driven through a
// latency-configurable RAM model, with a scoreboard of expected bias words.
module tb_bias_sched;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          calc_en, calc_end, npe_vld, ram_vld;
  logic [AW-1:0] addr_start, ram_addr;
  logic [7:0]    layers;
  logic [4:0]    part;
  logic          rd_en;
  logic [511:0]  ram_dat, bias_dat;
  logic          bias_vld, busy, done, uflow;

  always #5 clk = ~clk;

  bias_sched #(.RAM_ADDR_WIDTH(AW)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_calc_en       (calc_en),
    .i_calculate_end (calc_end),
    .i_addr_start_b  (addr_start),
    .i_output_layers (layers),
    .i_part_num      (part),
    .i_npe_dat_vld   (npe_vld),
    .o_ram_addr      (ram_addr),
    .o_ram_rd_en     (rd_en),
    .i_ram_dat_vld   (ram_vld),
    .i_ram_dat       (ram_dat),
    .o_bias_dat      (bias_dat),
    .o_bias_vld      (bias_vld),
    .o_busy          (busy),
    .o_done          (done),
    .o_underflow     (uflow)
  );

  // mode: 0 = run to completion, 1 = abort mid-RUN, 2 = reset mid-RUN
  typedef struct {
    string      name;
    logic [7:0] start;
    logic [7:0] layers;
    logic [4:0] part;
    int         lat;
    bit         npe_cont;
    int         mode;
    bit         exp_uf;
    int         exp_reads;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    int         due;
  } rd_t;

  vec_t         vecs [9];
  rd_t          pend [$];
  logic [511:0] sb [$];

  int         n_tests, n_fail;
  int         cyc;
  logic [7:0] cur_start, cur_layers;
  int         part_eff, lat;
  bit         npe_cont;
  int         reads_seen, pops, beat_cnt, done_cnt, done_cyc, last_beat_cyc;
  int         uf_err, max_infl, rd_after_abort, abort_cyc;
  bit         uf_exp, calc_pulse, abort_armed;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] ram_word(input logic [7:0] a);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = {a, 8'(i), ~a, 8'h5A ^ 8'(i)};
    return w;
  endfunction

  function automatic vec_t mk(input string n, input logic [7:0] s, input logic [7:0] l,
                              input logic [4:0] p, input int lt, input bit nc, input int m,
                              input bit uf, input int rd);
    vec_t v;
    v.name = n; v.start = s; v.layers = l; v.part = p; v.lat = lt;
    v.npe_cont = nc; v.mode = m; v.exp_uf = uf; v.exp_reads = rd;
    return v;
  endfunction

  // One cycle: observe DUT outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    rd_t        r;
    logic [7:0] ea;
    @(negedge clk);
    cyc++;
    if (rd_en) begin
      if (abort_cyc >= 0 && cyc > abort_cyc) begin
        rd_after_abort++;
      end else begin
        ea = cur_start + 8'(reads_seen);
        check($sformatf("rd_addr_%0d", reads_seen), ram_addr, ea);
        r.addr = ram_addr;
        r.due  = cyc + lat;
        pend.push_back(r);
        reads_seen++;
      end
    end
    if (reads_seen - pops > max_infl) max_infl = reads_seen - pops;
    if (uflow !== uf_exp) uf_err++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end

    // NOTE: bench inputs use blocking assignments at the falling edge, so they are
    // settled well before the DUT samples them on the next rising edge.
    calc_en    = calc_pulse;
    calc_pulse = 1'b0;
    calc_end   = 1'b0;
    if (abort_armed && bias_vld && pend.size() > 0 && pend[0].due > cyc) begin
      calc_end    = 1'b1;
      abort_armed = 1'b0;
      abort_cyc   = cyc;
    end
    npe_vld = !calc_end && (npe_cont ? busy : bias_vld);
    if (calc_en) begin
      uf_exp = 1'b0;
      if (cur_layers == 8'd0) last_beat_cyc = cyc;
    end
    if (npe_vld) begin
      if (!bias_vld) begin
        uf_exp = 1'b1;
      end else if (sb.size() == 0) begin
        check("bias_extra_beat", bias_vld, 1'b0);
      end else begin
        check($sformatf("bias_g%0d_b%0d", pops, beat_cnt), bias_dat, sb[0]);
        beat_cnt++;
        if (beat_cnt == part_eff) begin
          beat_cnt = 0;
          void'(sb.pop_front());
          pops++;
          if (pops == int'(cur_layers)) last_beat_cyc = cyc;
        end
      end
    end
    ram_vld = 1'b0;
    ram_dat = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r       = pend.pop_front();
      ram_vld = 1'b1;
      ram_dat = ram_word(r.addr);
    end
  endtask

  task automatic run_pass(input vec_t v);
    int         guard;
    logic [7:0] a;
    cur_start  = v.start;
    cur_layers = v.layers;
    part_eff   = (v.part == 5'd0) ? 1 : int'(v.part);
    lat        = v.lat;
    npe_cont   = v.npe_cont;
    sb.delete();
    for (int g = 0; g < int'(v.layers); g++) begin
      a = v.start + 8'(g);
      sb.push_back(ram_word(a));
    end
    reads_seen = 0; pops = 0; beat_cnt = 0; done_cnt = 0; done_cyc = -1;
    last_beat_cyc = -1; max_infl = 0; uf_err = 0; rd_after_abort = 0; abort_cyc = -1;
    abort_armed = (v.mode == 1);
    addr_start  = v.start;
    layers      = v.layers;
    part        = v.part;
    calc_pulse  = 1'b1;

    guard = 0;
    while (guard < 400) begin
      step();
      guard++;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        check({v.name, "_abort_busy"}, busy, 1'b0);
        check({v.name, "_abort_vld"}, bias_vld, 1'b0);
      end
      if (v.mode == 0 && done_cnt > 0) break;
      if (v.mode == 1 && abort_cyc >= 0 && cyc > abort_cyc + 3 && pend.size() == 0) break;
      if (v.mode == 2 && pops >= 1 && bias_vld) break;
    end
    check({v.name, "_no_timeout"}, guard < 400, 1'b1);

    if (v.mode == 2) begin
      check({v.name, "_uflow_pre"}, uflow, 1'b1);
      #2 rst_n = 1'b0;
      {calc_en, calc_end, npe_vld, ram_vld} = 4'b0;
      ram_dat = '0;
      #1;
      check({v.name, "_rst_rd_en"}, rd_en, 1'b0);
      check({v.name, "_rst_addr"}, ram_addr, '0);
      check({v.name, "_rst_bias_dat"}, bias_dat, '0);
      check({v.name, "_rst_bias_vld"}, bias_vld, 1'b0);
      check({v.name, "_rst_busy"}, busy, 1'b0);
      check({v.name, "_rst_done"}, done, 1'b0);
      check({v.name, "_rst_uflow"}, uflow, 1'b0);
      pend.delete();
      sb.delete();
      uf_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end

    step();
    step();
    check({v.name, "_uf_track"}, uf_err, 0);
    check({v.name, "_idle_busy"}, busy, 1'b0);
    if (v.mode == 1) begin
      check({v.name, "_no_done"}, done_cnt, 0);
      check({v.name, "_no_rd_after_abort"}, rd_after_abort, 0);
    end else begin
      check({v.name, "_reads"}, reads_seen, v.exp_reads);
      check({v.name, "_groups"}, pops, v.layers);
      check({v.name, "_done_cnt"}, done_cnt, 1);
      check({v.name, "_done_time"}, done_cyc, last_beat_cyc + 1);
      check({v.name, "_uflow"}, uflow, v.exp_uf);
      check({v.name, "_inflight_le2"}, max_infl > 2, 1'b0);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    uf_exp = 1'b0; calc_pulse = 1'b0; abort_armed = 1'b0; abort_cyc = -1;
    rst_n = 1'b0;
    {calc_en, calc_end, npe_vld, ram_vld} = 4'b0;
    addr_start = '0; layers = '0; part = '0; ram_dat = '0;

    vecs[0] = mk("basic",      8'h10, 8'd3, 5'd4, 1, 1'b0, 0, 1'b0, 3);
    vecs[1] = mk("wrap",       8'hFE, 8'd4, 5'd2, 1, 1'b0, 0, 1'b0, 4);
    vecs[2] = mk("backpress",  8'h20, 8'd6, 5'd1, 3, 1'b1, 0, 1'b1, 6);
    vecs[3] = mk("zero_layer", 8'h40, 8'd0, 5'd3, 1, 1'b0, 0, 1'b0, 0);
    vecs[4] = mk("part_zero",  8'h50, 8'd3, 5'd0, 2, 1'b0, 0, 1'b0, 3);
    vecs[5] = mk("abort",      8'h60, 8'd4, 5'd4, 3, 1'b0, 1, 1'b0, 0);
    vecs[6] = mk("post_abort", 8'h10, 8'd3, 5'd4, 1, 1'b0, 0, 1'b0, 3);
    vecs[7] = mk("mid_reset",  8'h30, 8'd4, 5'd2, 2, 1'b1, 2, 1'b1, 0);
    vecs[8] = mk("post_reset", 8'h10, 8'd3, 5'd4, 1, 1'b0, 0, 1'b0, 3);

    repeat (2) @(negedge clk);
    check("reset_rd_en", rd_en, 1'b0);
    check("reset_addr", ram_addr, '0);
    check("reset_bias_dat", bias_dat, '0);
    check("reset_bias_vld", bias_vld, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_uflow", uflow, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_pass(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
